// File: rtl/lsu_ctrl.sv
// Load/store unit: word-only memory access with read-modify-write for sub-word stores.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses across two words.
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 256,
    parameter bit          RANGE_CHK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);

    localparam logic [31:0] MaxAddr = 32'(MEM_BYTES - 1);

    typedef enum logic [2:0] {StIdle, StRd0, StRd1, StWr0, StWr1, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q, cross_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, old0_q, old1_q;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        split_en;
`ifdef LSU_MISALIGN_SPLIT_EN
    assign split_en = 1'b1;
`else
    assign split_en = 1'b0;
`endif

    // Request decode, evaluated in IDLE on the live inputs
    logic [2:0]  req_bytes;
    logic [31:0] req_last;
    logic        f3_ok, misalign, req_cross, range_err, req_err, accept;

    always_comb begin
        unique case (req_funct3[1:0])
            2'b00:   req_bytes = 3'd1;
            2'b01:   req_bytes = 3'd2;
            default: req_bytes = 3'd4;
        endcase
    end

    assign f3_ok     = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                              : !(req_funct3 inside {3'b011, 3'b110, 3'b111});
    assign misalign  = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign req_cross = (({1'b0, req_addr[1:0]} + req_bytes) > 3'd4) && split_en;
    assign req_last  = req_addr + {29'd0, req_bytes} - 32'd1;
    assign range_err = RANGE_CHK && ((req_addr > MaxAddr) || (req_last > MaxAddr));
    assign req_err   = !f3_ok || (misalign && !split_en) || range_err;
    assign accept    = req_valid && (state_q == StIdle);

    logic [31:0] word0, word1;
    assign word0 = {addr_q[31:2], 2'b00};
    assign word1 = word0 + 32'd4;

    // Load extraction from a two-word little-endian window
    logic [4:0]  lane_sh;
    logic [63:0] ld_win;
    logic [31:0] ld_word, ld_ext;
    assign lane_sh = {addr_q[1:0], 3'b000};
    assign ld_win  = (state_q == StRd1) ? {mem_rd_data, old0_q} : {32'h0, mem_rd_data};
    assign ld_word = 32'(ld_win >> lane_sh);

    always_comb begin
        unique case (funct3_q)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b010:  ld_ext = ld_word;
            3'b100:  ld_ext = {24'h0, ld_word[7:0]};
            3'b101:  ld_ext = {16'h0, ld_word[15:0]};
            default: ld_ext = 32'h0;
        endcase
    end

    // Store merge; a full aligned word masks out the stale old data entirely
    logic [31:0] st_mask32;
    logic [63:0] st_mask, st_data, merged;
    always_comb begin
        unique case (funct3_q[1:0])
            2'b00:   st_mask32 = 32'h0000_00FF;
            2'b01:   st_mask32 = 32'h0000_FFFF;
            default: st_mask32 = 32'hFFFF_FFFF;
        endcase
    end
    assign st_mask = {32'h0, st_mask32} << lane_sh;
    assign st_data = {32'h0, wdata_q} << lane_sh;
    assign merged  = ({old1_q, old0_q} & ~st_mask) | (st_data & st_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            cross_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            old0_q      <= 32'h0;
            old1_q      <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                we_q     <= req_we;
                cross_q  <= req_cross;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state_q == StRd0) old0_q <= mem_rd_data;
            if (state_q == StRd1) old1_q <= mem_rd_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = 32'h0;
        mem_wr_data = 32'h0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_d     = StResp;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else if (req_we && req_funct3[1:0] == 2'b10 && !req_cross) begin
                        state_d = StWr0;
                    end else begin
                        state_d = StRd0;
                    end
                end
            end
            StRd0: begin
                mem_addr = word0;
                if (cross_q) begin
                    state_d = StRd1;
                end else if (!we_q) begin
                    state_d     = StResp;
                    rsp_rdata_d = ld_ext;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = StWr0;
                end
            end
            StRd1: begin
                mem_addr = word1;
                if (!we_q) begin
                    state_d     = StResp;
                    rsp_rdata_d = ld_ext;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = StWr0;
                end
            end
            StWr0: begin
                mem_addr    = word0;
                mem_wr_en   = 1'b1;
                mem_wr_data = merged[31:0];
                if (cross_q) begin
                    state_d = StWr1;
                end else begin
                    state_d     = StResp;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            StWr1: begin
                mem_addr    = word1;
                mem_wr_en   = 1'b1;
                mem_wr_data = merged[63:32];
                state_d     = StResp;
                rsp_rdata_d = 32'h0;
                rsp_err_d   = 1'b0;
            end
            StResp: begin
                rsp_valid = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: word memory model, scoreboard of expected responses.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    lsu_ctrl #(.MEM_BYTES(256), .RANGE_CHK(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    int          wr_count = 0;
    assign mem_rd_data = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr[7:2]] <= mem_wr_data;
            wr_count           <= wr_count + 1;
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          writes;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_lat, input int exp_wr);
        exp_t e;
        int   lat;
        int   wr0;
        sb_q.push_back('{exp_err, exp_rd, exp_lat, exp_wr});
        wr0 = wr_count;
        @(negedge clk);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'hBAD0_BAD0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = sb_q.pop_front();
        if (!rsp_valid) begin
            check({tag, ".timeout"}, 32'(lat), 32'(e.lat));
        end else begin
            check({tag, ".lat"}, 32'(lat), 32'(e.lat));
            check({tag, ".err"}, 32'(rsp_err), 32'(e.err));
            check({tag, ".rdata"}, rsp_rdata, e.rdata);
            @(negedge clk);
            check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
            check({tag, ".hold"}, rsp_rdata, e.rdata);
        end
        check({tag, ".writes"}, 32'(wr_count - wr0), 32'(e.writes));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        check({tag, ".valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".err"}, 32'(rsp_err), 32'd0);
        check({tag, ".rdata"}, rsp_rdata, 32'd0);
        check({tag, ".wr_en"}, 32'(mem_wr_en), 32'd0);
        check({tag, ".addr"}, mem_addr, 32'd0);
        check({tag, ".wdata"}, mem_wr_data, 32'd0);
    endtask

    initial begin
        int wr_snap;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Word store/load
        do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1);
        check("mem10", mem[4], 32'hDEADBEEF);
        do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 0);

        // Byte RMW and byte load extension
        do_req("sw20", 1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0, 32'h0, 2, 1);
        do_req("sb22", 1'b1, 3'b000, 32'h22, 32'h5555_55AA, 1'b0, 32'h0, 3, 1);
        check("mem20", mem[8], 32'h11AA3344);
        do_req("lb22", 1'b0, 3'b000, 32'h22, 32'h0, 1'b0, 32'hFFFFFFAA, 2, 0);
        do_req("lbu22", 1'b0, 3'b100, 32'h22, 32'h0, 1'b0, 32'h000000AA, 2, 0);

        // Half extension and half RMW
        do_req("sw30", 1'b1, 3'b010, 32'h30, 32'h80017FFE, 1'b0, 32'h0, 2, 1);
        do_req("lh32", 1'b0, 3'b001, 32'h32, 32'h0, 1'b0, 32'hFFFF8001, 2, 0);
        do_req("lhu32", 1'b0, 3'b101, 32'h32, 32'h0, 1'b0, 32'h00008001, 2, 0);
        do_req("lh30", 1'b0, 3'b001, 32'h30, 32'h0, 1'b0, 32'h00007FFE, 2, 0);
        do_req("sh30", 1'b1, 3'b001, 32'h30, 32'hFFFF1234, 1'b0, 32'h0, 3, 1);
        check("mem30", mem[12], 32'h80011234);

        // Range boundary and illegal encodings
        do_req("swfc", 1'b1, 3'b010, 32'hFC, 32'hCAFEF00D, 1'b0, 32'h0, 2, 1);
        do_req("lbuff", 1'b0, 3'b100, 32'hFF, 32'h0, 1'b0, 32'h000000CA, 2, 0);
        do_req("sw100", 1'b1, 3'b010, 32'h100, 32'h12345678, 1'b1, 32'h0, 1, 0);
        check("mem0", mem[0], 32'h0);
        do_req("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0);
        do_req("st011", 1'b1, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0);
        check("mem10b", mem[4], 32'hDEADBEEF);

`ifdef LSU_MISALIGN_SPLIT_EN
        do_req("sw40", 1'b1, 3'b010, 32'h40, 32'h44332211, 1'b0, 32'h0, 2, 1);
        do_req("sw44", 1'b1, 3'b010, 32'h44, 32'h88776655, 1'b0, 32'h0, 2, 1);
        do_req("lw43", 1'b0, 3'b010, 32'h43, 32'h0, 1'b0, 32'h77665544, 3, 0);
        do_req("sw42", 1'b1, 3'b010, 32'h42, 32'hA1B2C3D4, 1'b0, 32'h0, 5, 2);
        check("mem40", mem[16], 32'hC3D42211);
        check("mem44", mem[17], 32'h8877A1B2);
        do_req("lh41", 1'b0, 3'b001, 32'h41, 32'h0, 1'b0, 32'hFFFFD422, 2, 0);
        do_req("lwfe", 1'b0, 3'b010, 32'hFE, 32'h0, 1'b1, 32'h0, 1, 0);
`else
        do_req("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 32'h0, 1, 0);
        do_req("lh31", 1'b0, 3'b001, 32'h31, 32'h0, 1'b1, 32'h0, 1, 0);
        do_req("sw12", 1'b1, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, 1, 0);
        check("mem10c", mem[4], 32'hDEADBEEF);
`endif

        // Reset during RD0 of a byte store: nothing written, outputs back to reset
        do_req("lb22b", 1'b0, 3'b000, 32'h22, 32'h0, 1'b0, 32'hFFFFFFAA, 2, 0);
        wr_snap = wr_count;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h21;
        req_wdata  = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst.in_rd0", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst.mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst.writes", 32'(wr_count - wr_snap), 32'd0);
        check("rst.mem20", mem[8], 32'h11AA3344);
        check_reset_outputs("rst.after");
        do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h11AA3344, 2, 0);

        check("sb.empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit between the execute stage and the word-only data memory.
- Accepts one load/store request at a time. Generates word-aligned memory accesses and does read-modify-write for byte and half stores, because the memory has no byte enables.
- Extracts and sign- or zero-extends load data, then returns it with a one-cycle response pulse.
- Drives the memory's write enable, address and write data, and consumes its combinational read data.

Parameters:
- MEM_BYTES, 256, size of the data memory in bytes; any access with a byte above MEM_BYTES-1 is a range error.
- RANGE_CHK, 1, 1 enables the range check; 0 disables it and addresses wrap modulo the memory size.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted when req_valid & req_ready.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: misaligned, range or illegal-funct3 error.
- mem_wr_en  out  1  memory write enable.
- mem_addr  out  32  memory byte address, always {word[31:2],2'b00}.
- mem_wr_data  out  32  memory write word.
- mem_rd_data  in  32  combinational memory read word at mem_addr.

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
- Reset mid-operation aborts the transaction. No write is issued after release; writes already committed stay in memory.
- Request capture: on acceptance, latch req_we, req_funct3, req_addr and req_wdata. req_ready=0 in every state except IDLE. Inputs are ignored while busy.
- Error check in IDLE, with no memory access on any error; next state is RESP with rsp_err=1:
  - funct3 illegal for the access type (load 011/110/111; store other than 000/001/010).
  - half access with addr[0]=1, or word access with addr[1:0]!=0 (macro off).
  - RANGE_CHK=1 and the last byte of the access is above MEM_BYTES-1.
- FSM states: IDLE, RD0, RD1, WR0, WR1, RESP.
- Load: IDLE→RD0. mem_addr holds the word address and mem_rd_data is captured at the end of RD0. Next state is RESP. rsp_valid is high 2 cycles after acceptance.
- SW, aligned: IDLE→WR0 with mem_wr_en=1 and mem_wr_data=wdata. Next state is RESP.
- SB/SH: IDLE→RD0 (capture the old word)→WR0.
  - In WR0, merge wdata into the lane(s) selected by addr[1:0] and assert mem_wr_en for exactly one cycle.
  - Next state is RESP, so rsp_valid rises 3 cycles after acceptance.
- Load extraction: byte lane addr[1:0], half lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready returns to 1 in the cycle after RESP.
- rsp_rdata and rsp_err hold their value until the next RESP.
- mem_wr_en is 0 in every state other than WR0/WR1.
- Back-to-back requests are allowed, with one dead cycle between transactions (the RESP state).
- With the optional feature on, each RD/WR state addresses its own word: word0 = {addr[31:2],00}, word1 = word0+4, wrapping modulo 2^32 before the range check.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are legal.
  - An access contained within one word uses the single-word path. A half at offset 1 uses lanes 1-2.
  - An access crossing a word boundary uses both words, little-endian byte order:
    - Load: RD0→RD1→RESP.
    - Store: RD0→RD1→WR0→WR1→RESP.
  - Both writes always complete unless reset intervenes.
- Undefined: misaligned accesses return rsp_err=1 with no memory access. States RD1 and WR1 are never entered.

Test Plan:
- Word store/load: SW 0xDEADBEEF @0x10, then LW @0x10 → one mem_wr_en pulse at 0x10; rsp_rdata=0xDEADBEEF 2 cycles after acceptance; rsp_err=0.
- Byte RMW: mem[0x20]=0x11223344, SB 0xAA @0x22 → RD0 then WR0 writes 0x11AA3344 at 0x20. Then LB @0x22 → 0xFFFFFFAA, and LBU @0x22 → 0x000000AA.
- Half extension: mem[0x30]=0x8001_7FFE. LH @0x32 → 0xFFFF8001; LHU @0x32 → 0x00008001; LH @0x30 → 0x00007FFE.
- Errors (macro off): LW @0x11 → rsp_err=1, rdata=0, no mem_wr_en. SW @0x100 with MEM_BYTES=256 → rsp_err=1 with no write. Load funct3=011 → rsp_err=1.
- Split (macro on): mem[0x40]=0x44332211, mem[0x44]=0x88776655. LW @0x43 → 0x77665544. SW 0xA1B2C3D4 @0x42 → mem[0x40]=0xC3D42211 and mem[0x44]=0x8877A1B2.
- Reset mid-op: assert rst_n=0 during RD0 of an SB → no mem_wr_en afterwards, memory unchanged, outputs at reset values, req_ready=1 after release.
